// File: rtl/calc_core_if.sv
// Operand/result bundle between io_serdes (master) and calc_core (slave).
interface calc_core_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             start_calc;
  logic [WIDTH-1:0] z;
  logic             busy;
  logic             done;

  modport master (
    output a, b, op, start_calc,
    input  z, busy, done
  );

  modport slave (
    input  a, b, op, start_calc,
    output z, busy, done
  );
endinterface

// File: rtl/calc_core.sv
// Iterative radix-2 unit: shift-add unsigned multiply, one bit per clock.
// Define CALC_DIV_EN to add restoring unsigned divide on op=1.
module calc_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  calc_core_if.slave  calc
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic             start_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;   // multiplicand / dividend
  logic [WIDTH-1:0] opb;   // multiplier / divisor
  logic [WIDTH-1:0] acc;   // product / quotient
  logic             accept;

  assign accept = calc.start_calc & ~start_d & (state == IDLE);

`ifdef CALC_DIV_EN
  logic             op_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;

  // Shifted remainder kept at WIDTH+1 bits so the compare never loses the carry-out.
  always_comb begin
    rem_sh   = {rem, opa[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      calc.z    <= '0;
      calc.busy <= 1'b0;
      calc.done <= 1'b0;
`ifdef CALC_DIV_EN
      op_q      <= 1'b0;
      rem       <= '0;
`endif
    end else begin
      start_d   <= calc.start_calc;
      calc.done <= 1'b0;
      case (state)
        IDLE: begin
          calc.busy <= accept;
          if (accept) begin
            opa   <= calc.a;
            opb   <= calc.b;
`ifdef CALC_DIV_EN
            op_q  <= calc.op;
`endif
            state <= LOAD;
          end
        end
        LOAD: begin
          acc   <= '0;
`ifdef CALC_DIV_EN
          rem   <= '0;
`endif
          cnt   <= CW'(WIDTH - 1);
          state <= RUN;
        end
        RUN: begin
`ifdef CALC_DIV_EN
          if (op_q) begin
            // A borrow (rem_diff MSB set) means the divisor did not fit: restore.
            if (rem_diff[WIDTH]) begin
              rem <= rem_sh[WIDTH-1:0];
            end else begin
              rem <= rem_diff[WIDTH-1:0];
            end
            acc <= {acc[WIDTH-2:0], ~rem_diff[WIDTH]};
            opa <= opa << 1;
          end else
`endif
          begin
            if (opb[0]) begin
              acc <= acc + opa;
            end
            opa <= opa << 1;
            opb <= opb >> 1;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          // busy stays high one more cycle; IDLE clears it unless a new start lands.
          calc.z    <= acc;
          calc.done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: stimulus pushes expected z, a negedge monitor pops on done.
module tb_calc_core;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;

  calc_core_if #(.WIDTH(W)) bus ();

  calc_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .calc  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

`ifdef CALC_DIV_EN
  localparam logic [W-1:0] EXP_DIV = 32'h0000000E;
  localparam logic [W-1:0] EXP_DV0 = 32'hFFFFFFFF;
`else
  localparam logic [W-1:0] EXP_DIV = 32'h000002BC;
  localparam logic [W-1:0] EXP_DV0 = 32'h00000000;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("z", bus.z, exp_q.pop_front());
      end
    end
  end

  // mode 0: plain; 1: hold start high 100 cycles; 2: re-edge start and change a/b mid-RUN
  task automatic do_calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [W-1:0] expz, input int mode);
    int lat = 0;
    @(negedge clk);
    bus.start_calc = 1'b0;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.start_calc = 1'b1;
    exp_q.push_back(expz);
    @(posedge clk);
    #1;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    for (int k = 1; k <= int'(W) + 6; k++) begin
      @(posedge clk);
      #1;
      if (mode == 2) begin
        if (k == 5) begin
          bus.a = 32'hDEADBEEF;
          bus.b = 32'h12345678;
          bus.op = ~op;
          bus.start_calc = 1'b0;
        end
        if (k == 8) bus.start_calc = 1'b1;
        if (k == 10) bus.start_calc = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, W + 2);
    @(posedge clk);
    #1;
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
    if (mode == 1) begin
      repeat (100) @(posedge clk);
      #1;
      chk("hold_busy", {31'd0, bus.busy}, 32'd0);
      chk("hold_z_stable", bus.z, expz);
    end
    if (mode == 2) begin
      repeat (5) @(posedge clk);
      #1;
      chk("dropped_edge_idle", {31'd0, bus.busy}, 32'd0);
    end
    @(negedge clk);
    bus.start_calc = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.op = 1'b0;
    bus.start_calc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_z", bus.z, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_calc(32'd7, 32'd6, 1'b0, 32'h0000002A, 0);
    do_calc(32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'hFFFE0001, 0);
    do_calc(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 0);
    do_calc(32'd100, 32'd7, 1'b1, EXP_DIV, 0);
    do_calc(32'h12345678, 32'd0, 1'b1, EXP_DV0, 0);
    do_calc(32'd0, 32'h89ABCDEF, 1'b0, 32'd0, 0);
    do_calc(32'd11, 32'd13, 1'b0, 32'd143, 1);
    do_calc(32'd9, 32'd5, 1'b0, 32'd45, 2);

    // reset mid-RUN: no result expected
    @(negedge clk);
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.op = 1'b0;
    bus.start_calc = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_z", bus.z, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.start_calc = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_stays_idle", {31'd0, bus.busy}, 32'd0);
    do_calc(32'd7, 32'd6, 1'b0, 32'h0000002A, 0);

    // start edge coincident with reset is ignored
    @(negedge clk);
    reset = 1'b1;
    bus.start_calc = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start_calc = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_start_ignored", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
